// File: rtl/sdram_arb2.sv
// Two-requester round-robin arbiter in front of a single SDRAM controller port.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RECOVER, with a WAIT timeout.
module sdram_arb2 #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              m0_req,
    input  logic              m0_rh_wl,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data_w,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_data_r,
    output logic              m0_data_r_en,
    input  logic              m1_req,
    input  logic              m1_rh_wl,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data_w,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_data_r,
    output logic              m1_data_r_en,
    output logic              s_req,
    output logic              s_rh_wl,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_data_w,
    input  logic              s_ack,
    input  logic [DATA_W-1:0] s_data_r,
    input  logic              s_data_r_en,
    output logic [1:0]        grant,
    output logic              err_timeout
);

    localparam int unsigned CNT_W = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic               last_m1;
    logic               any_req;
    logic               win_m1;
    logic               timeout_hit;

    assign any_req     = m0_req | m1_req;
    // m1 wins when alone, or on a tie when m0 was served last
    assign win_m1      = m1_req & (~m0_req | ~last_m1);
    assign timeout_hit = (state == WAIT) && !s_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign m0_data_r = s_data_r;
    assign m1_data_r = s_data_r;

    // State register
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (s_ack || timeout_hit) state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        s_req        = 1'b0;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        m0_data_r_en = 1'b0;
        m1_data_r_en = 1'b0;
        if (state == ISSUE) begin
            s_req = 1'b1;
        end
        if (state == RECOVER) begin
            m0_ack = grant[0];
            m1_ack = grant[1];
        end
        if (state == WAIT) begin
            m0_data_r_en = s_data_r_en & grant[0];
            m1_data_r_en = s_data_r_en & grant[1];
        end
    end

    // Grant, command latches, wait counter, round-robin pointer, sticky error
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            grant       <= 2'b00;
            s_rh_wl     <= 1'b1;
            s_addr      <= '0;
            s_data_w    <= '0;
            wait_cnt    <= '0;
            last_m1     <= 1'b1;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= win_m1 ? 2'b10 : 2'b01;
                        s_rh_wl  <= win_m1 ? m1_rh_wl  : m0_rh_wl;
                        s_addr   <= win_m1 ? m1_addr   : m0_addr;
                        s_data_w <= win_m1 ? m1_data_w : m0_data_w;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (timeout_hit) begin
                        err_timeout <= 1'b1;
                    end
                end
                RECOVER: begin
                    last_m1 <= grant[1];
                    grant   <= 2'b00;
                end
                default: begin
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arb2.sv
// Self-checking bench for sdram_arb2: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_sdram_arb2;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 8;

    logic          clk;
    logic          reset_l;
    logic          m0_req, m0_rh_wl, m0_ack, m0_data_r_en;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_data_w, m0_data_r;
    logic          m1_req, m1_rh_wl, m1_ack, m1_data_r_en;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_data_w, m1_data_r;
    logic          s_req, s_rh_wl, s_ack, s_data_r_en;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data_w, s_data_r;
    logic [1:0]    grant;
    logic          err_timeout;

    int checks   = 0;
    int failures = 0;
    bit model_last = 1'b1;  // 1: m1 served last
    bit model_err  = 1'b0;

    sdram_arb2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_l(reset_l),
        .m0_req(m0_req), .m0_rh_wl(m0_rh_wl), .m0_addr(m0_addr), .m0_data_w(m0_data_w),
        .m0_ack(m0_ack), .m0_data_r(m0_data_r), .m0_data_r_en(m0_data_r_en),
        .m1_req(m1_req), .m1_rh_wl(m1_rh_wl), .m1_addr(m1_addr), .m1_data_w(m1_data_w),
        .m1_ack(m1_ack), .m1_data_r(m1_data_r), .m1_data_r_en(m1_data_r_en),
        .s_req(s_req), .s_rh_wl(s_rh_wl), .s_addr(s_addr), .s_data_w(s_data_w),
        .s_ack(s_ack), .s_data_r(s_data_r), .s_data_r_en(s_data_r_en),
        .grant(grant), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        m0_req = 0; m0_rh_wl = 0; m0_addr = '0; m0_data_w = '0;
        m1_req = 0; m1_rh_wl = 0; m1_addr = '0; m1_data_w = '0;
        s_ack = 0; s_data_r = '0; s_data_r_en = 0;
    endtask

    task automatic test_reset();
        reset_l = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL reset_s_req got=%b exp=0", s_req); end
        checks++; if (s_rh_wl !== 1'b1) begin failures++; $display("FAIL reset_s_rh_wl got=%b exp=1", s_rh_wl); end
        checks++; if ({s_addr, s_data_w} !== 40'h0) begin failures++; $display("FAIL reset_s_bus got=%h/%h exp=0/0", s_addr, s_data_w); end
        checks++; if ({m0_ack, m1_ack, err_timeout} !== 3'b000) begin failures++; $display("FAIL reset_ack_err got=%b exp=000", {m0_ack, m1_ack, err_timeout}); end
        reset_l = 1;
        model_last = 1'b1;
        model_err  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int t_req = -1, t_ack = -1, nreq = 0, nack = 0, nbad = 0;
        m0_req = 1; m0_rh_wl = 0; m0_addr = '0; m0_data_w = 16'hf055;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (s_req) begin
                nreq++;
                if (t_req < 0) t_req = k;
                checks++;
                if (s_rh_wl !== 1'b0 || s_data_w !== 16'hf055 || s_addr !== 24'h0) begin
                    failures++; $display("FAIL wr_cmd got=%b/%h/%h exp=0/000000/f055", s_rh_wl, s_addr, s_data_w);
                end
            end
            if (m0_ack) begin nack++; if (t_ack < 0) t_ack = k; m0_req = 0; end
            if (m1_ack) nbad++;
            if (t_req >= 0 && (t_ack < 0 || k <= t_ack)) begin
                checks++; if (grant !== 2'b01) begin failures++; $display("FAIL wr_grant k=%0d got=%b exp=01", k, grant); end
            end
            s_ack = (t_req >= 0 && k == t_req + 5);
        end
        s_ack = 0;
        checks++; if (nreq != 1) begin failures++; $display("FAIL wr_nreq got=%0d exp=1", nreq); end
        checks++; if (t_ack != t_req + 6) begin failures++; $display("FAIL wr_ack_lat got=%0d exp=%0d", t_ack, t_req + 6); end
        checks++; if (nack != 1 || nbad != 0) begin failures++; $display("FAIL wr_acks got=%0d/%0d exp=1/0", nack, nbad); end
        model_last = 1'b0;
    endtask

    task automatic test_read();
        int t_req = -1, t_ack = -1, nreq = 0, nack = 0, nbad = 0, ndat = 0;
        m1_req = 1; m1_rh_wl = 1; m1_addr = '0; m1_data_w = '0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (s_req) begin
                nreq++;
                if (t_req < 0) t_req = k;
                checks++;
                if (s_rh_wl !== 1'b1 || grant !== 2'b10) begin
                    failures++; $display("FAIL rd_cmd got=%b/%b exp=1/10", s_rh_wl, grant);
                end
            end
            if (m1_ack) begin nack++; if (t_ack < 0) t_ack = k; m1_req = 0; end
            if (m0_ack) nbad++;
            s_data_r_en = (t_req >= 0 && k == t_req + 2);
            s_data_r    = s_data_r_en ? 16'hf055 : 16'h0;
            s_ack       = (t_req >= 0 && k == t_req + 3);
            if (s_data_r_en) begin
                #1;
                ndat++;
                checks++;
                if (m1_data_r_en !== 1'b1 || m0_data_r_en !== 1'b0 || m1_data_r !== 16'hf055) begin
                    failures++; $display("FAIL rd_data got=%b/%b/%h exp=1/0/f055", m1_data_r_en, m0_data_r_en, m1_data_r);
                end
            end
        end
        s_ack = 0; s_data_r_en = 0;
        checks++; if (nreq != 1 || ndat != 1) begin failures++; $display("FAIL rd_nreq got=%0d/%0d exp=1/1", nreq, ndat); end
        checks++; if (t_ack != t_req + 4) begin failures++; $display("FAIL rd_ack_lat got=%0d exp=%0d", t_ack, t_req + 4); end
        checks++; if (nack != 1 || nbad != 0) begin failures++; $display("FAIL rd_acks got=%0d/%0d exp=1/0", nack, nbad); end
        model_last = 1'b1;
    endtask

    task automatic test_stray_ack();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({s_req, grant, m0_ack, m1_ack} !== 5'b0) begin
                failures++; $display("FAIL stray_idle k=%0d got=%b exp=00000", k, {s_req, grant, m0_ack, m1_ack});
            end
            s_ack       = k[0];
            s_data_r_en = 1;
            s_data_r    = 16'hbeef;
            #1;
            checks++;
            if ({m0_data_r_en, m1_data_r_en} !== 2'b00 || m0_data_r !== 16'hbeef) begin
                failures++; $display("FAIL stray_rd_en got=%b/%h exp=00/beef", {m0_data_r_en, m1_data_r_en}, m0_data_r);
            end
        end
        s_ack = 0; s_data_r_en = 0;
    endtask

    task automatic test_simultaneous();
        int n_iss = 0, n_ack = 0, last_sreq = -100, t_due = -1;
        logic [1:0] eg;
        m0_req = 1; m0_rh_wl = 0; m0_addr = 24'h000111; m0_data_w = 16'h1234;
        m1_req = 1; m1_rh_wl = 1; m1_addr = 24'h000222; m1_data_w = 16'h5678;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (s_req) begin
                if (n_iss < 4) begin
                    eg = (n_iss % 2 == 0) ? 2'b01 : 2'b10;
                    checks++; if (grant !== eg) begin failures++; $display("FAIL sim_grant n=%0d got=%b exp=%b", n_iss, grant, eg); end
                    checks++;
                    if (s_addr !== ((eg == 2'b01) ? 24'h000111 : 24'h000222)) begin
                        failures++; $display("FAIL sim_addr n=%0d got=%h", n_iss, s_addr);
                    end
                end
                if (n_iss > 0) begin
                    checks++; if (k - last_sreq < 4) begin failures++; $display("FAIL sim_gap got=%0d exp>=4", k - last_sreq); end
                end
                last_sreq = k;
                n_iss++;
                t_due = k + int'($urandom_range(1, 3));
            end
            if (m0_ack || m1_ack) begin
                n_ack++;
                if (n_ack == 4) begin m0_req = 0; m1_req = 0; end
            end
            s_ack = (k == t_due);
        end
        s_ack = 0;
        checks++; if (n_iss != 4 || n_ack != 4) begin failures++; $display("FAIL sim_count got=%0d/%0d exp=4/4", n_iss, n_ack); end
        model_last = 1'b1;
    endtask

    task automatic test_reset_mid();
        int t = -1, nack = 0;
        bit did_reset = 0;
        // m0 served last so that a retained pointer would favour m1
        m0_req = 1; m0_rh_wl = 0; m0_addr = 24'h5; m0_data_w = 16'h5;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (s_req) t = k;
            if (m0_ack) begin nack++; m0_req = 0; end
            s_ack = (t >= 0 && k == t + 1);
        end
        s_ack = 0;
        checks++; if (nack != 1) begin failures++; $display("FAIL rst_pre_ack got=%0d exp=1", nack); end
        t = -1;
        m0_req = 1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (s_req && t < 0) t = k;
            if (t >= 0 && k == t + 2) begin
                reset_l = 0;
                #1;
                did_reset = 1;
                checks++;
                if ({grant, s_req, m0_ack, m1_ack} !== 5'b0) begin
                    failures++; $display("FAIL rst_async got=%b exp=00000", {grant, s_req, m0_ack, m1_ack});
                end
                m0_req = 0;
                break;
            end
        end
        checks++; if (!did_reset) begin failures++; $display("FAIL rst_no_wait got=0 exp=1"); end
        repeat (2) @(negedge clk);
        reset_l = 1;
        model_last = 1'b1;
        model_err  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({grant, s_req, m0_ack, m1_ack} !== 5'b0) begin
                failures++; $display("FAIL rst_after k=%0d got=%b exp=00000", k, {grant, s_req, m0_ack, m1_ack});
            end
        end
        t = -1; nack = 0;
        m0_req = 1; m1_req = 1; m1_addr = 24'h9;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (s_req && t < 0) begin
                t = k;
                checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rst_tie got=%b exp=01", grant); end
            end
            if (m0_ack || m1_ack) begin nack++; m0_req = 0; m1_req = 0; end
            s_ack = (t >= 0 && k == t + 1);
        end
        s_ack = 0;
        checks++; if (nack != 1) begin failures++; $display("FAIL rst_tie_ack got=%0d exp=1", nack); end
        model_last = 1'b0;
    endtask

    task automatic test_timeout();
        int t = -1, t_ack = -1, nack = 0;
        m1_req = 1; m1_rh_wl = 0; m1_addr = 24'h7; m1_data_w = 16'h7;
        s_ack = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (s_req && t < 0) t = k;
            if (t >= 0 && k <= t + int'(TO)) begin
                checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_early k=%0d got=1 exp=0", k - t); end
            end
            if (m1_ack) begin
                t_ack = k;
                m1_req = 0;
                checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", err_timeout); end
            end
        end
        checks++; if (t_ack != t + int'(TO) + 1) begin failures++; $display("FAIL to_ack_lat got=%0d exp=%0d", t_ack, t + int'(TO) + 1); end
        model_err  = 1'b1;
        model_last = 1'b1;
        t = -1;
        m0_req = 1; m0_rh_wl = 1; m0_addr = 24'h8;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_req && t < 0) t = k;
            if (m0_ack) begin nack++; m0_req = 0; end
            s_ack = (t >= 0 && k == t + 2);
        end
        s_ack = 0;
        checks++; if (nack != 1 || err_timeout !== 1'b1) begin failures++; $display("FAIL to_next got=%0d/%b exp=1/1", nack, err_timeout); end
        model_last = 1'b0;
    endtask

    task automatic test_random();
        int t_issue = -100, t_rec = -100, last_sreq = -100, owner = 0, lat = 1;
        bit to = 0, busy, inw;
        bit act [2];
        logic          rw [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] dw [2];
        logic          o_rw [2];
        logic [AW-1:0] o_ad [2];
        logic [DW-1:0] o_dw [2];
        logic          l_rw = 1'b0;
        logic [AW-1:0] l_ad = '0;
        logic [DW-1:0] l_dw = '0;
        logic [1:0]    eg, een;
        for (int n = 0; n < 2; n++) begin act[n] = 0; rw[n] = 0; ad[n] = '0; dw[n] = '0; end
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            busy = (k >= t_issue && k <= t_rec);
            inw  = (k > t_issue && k < t_rec);
            if (k == t_rec && to) model_err = 1'b1;
            eg = busy ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++; if (s_req !== (k == t_issue)) begin failures++; $display("FAIL rnd_s_req k=%0d got=%b exp=%b", k, s_req, k == t_issue); end
            checks++; if (grant !== eg) begin failures++; $display("FAIL rnd_grant k=%0d got=%b exp=%b", k, grant, eg); end
            checks++;
            if ({m1_ack, m0_ack} !== ((k == t_rec) ? eg : 2'b00)) begin
                failures++; $display("FAIL rnd_ack k=%0d got=%b exp=%b", k, {m1_ack, m0_ack}, (k == t_rec) ? eg : 2'b00);
            end
            checks++; if (err_timeout !== model_err) begin failures++; $display("FAIL rnd_err k=%0d got=%b exp=%b", k, err_timeout, model_err); end
            if (busy) begin
                checks++;
                if ({s_rh_wl, s_addr, s_data_w} !== {l_rw, l_ad, l_dw}) begin
                    failures++; $display("FAIL rnd_cmd k=%0d got=%b/%h/%h exp=%b/%h/%h", k, s_rh_wl, s_addr, s_data_w, l_rw, l_ad, l_dw);
                end
            end
            if (k == t_issue) begin
                checks++; if (k - last_sreq < 4) begin failures++; $display("FAIL rnd_gap k=%0d got=%0d exp>=4", k, k - last_sreq); end
                last_sreq = k;
            end
            // Owner completes: either re-requests immediately with a new command or drops
            if (k == t_rec) begin
                model_last = (owner == 1);
                act[owner] = 1'($urandom_range(0, 1));
                if (act[owner]) begin rw[owner] = 1'($urandom); ad[owner] = AW'($urandom); dw[owner] = DW'($urandom); end
            end
            for (int n = 0; n < 2; n++) begin
                if (!act[n] && $urandom_range(0, 3) == 0) begin
                    act[n] = 1; rw[n] = 1'($urandom); ad[n] = AW'($urandom); dw[n] = DW'($urandom);
                end
                if ((busy && k < t_rec && owner == n) || !act[n]) begin
                    o_rw[n] = 1'($urandom); o_ad[n] = AW'($urandom); o_dw[n] = DW'($urandom);
                end else begin
                    o_rw[n] = rw[n]; o_ad[n] = ad[n]; o_dw[n] = dw[n];
                end
            end
            m0_req = act[0]; m0_rh_wl = o_rw[0]; m0_addr = o_ad[0]; m0_data_w = o_dw[0];
            m1_req = act[1]; m1_rh_wl = o_rw[1]; m1_addr = o_ad[1]; m1_data_w = o_dw[1];
            s_ack       = inw ? (k == t_issue + lat && !to) : ($urandom_range(0, 7) == 0);
            s_data_r_en = ($urandom_range(0, 2) == 0);
            s_data_r    = DW'($urandom);
            #1;
            een = {inw && owner == 1 && s_data_r_en, inw && owner == 0 && s_data_r_en};
            checks++; if ({m1_data_r_en, m0_data_r_en} !== een) begin failures++; $display("FAIL rnd_rd_en k=%0d got=%b exp=%b", k, {m1_data_r_en, m0_data_r_en}, een); end
            checks++;
            if (m0_data_r !== s_data_r || m1_data_r !== s_data_r) begin
                failures++; $display("FAIL rnd_rd_data k=%0d got=%h/%h exp=%h", k, m0_data_r, m1_data_r, s_data_r);
            end
            // Arbitration decision when the arbiter is idle and someone is requesting
            if (!busy && (act[0] || act[1])) begin
                owner   = (act[0] && act[1]) ? (model_last ? 0 : 1) : (act[1] ? 1 : 0);
                l_rw    = rw[owner]; l_ad = ad[owner]; l_dw = dw[owner];
                t_issue = k + 1;
                lat     = ($urandom_range(0, 9) == 0) ? int'(TO) + 3 : int'($urandom_range(1, 6));
                to      = (lat > int'(TO));
                t_rec   = t_issue + (to ? int'(TO) : lat) + 1;
            end
        end
        idle_inputs();
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stray_ack();
        test_simultaneous();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
